// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : First-word-fall-through byte FIFO between uart_rx and the CPU
//            peripheral bus. Optional interrupt request is compiled in when
//            UART_RX_FIFO_IRQ_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int IRQ_LEVEL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_dv,
    input  logic [7:0]        rx_byte,
    input  logic              rd,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              clr_overrun,
    input  logic              irq_en,
    output logic              irq
);

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wp;
    logic [ADDR_W-1:0] r_rp;
    logic [ADDR_W:0]   r_count;
    logic              r_overrun;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [ADDR_W:0]   w_count_next;
    logic              w_overrun_next;

    // Flags come from the count register only, never from the strobes.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_DEPTH);

    // A pop frees a slot in the same cycle, so a push while full is still taken.
    assign w_pop  = rd & ~w_empty;
    assign w_push = rx_dv & (~w_full | w_pop);
    assign w_drop = rx_dv & ~w_push;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Set beats clear when both happen in one cycle.
    assign w_overrun_next = w_drop | (r_overrun & ~clr_overrun);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            r_count   <= w_count_next;
            r_overrun <= w_overrun_next;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wp] <= rx_byte;
        end
    end

    assign rd_data = w_empty ? 8'h00 : r_mem[r_rp];
    assign empty   = w_empty;
    assign full    = w_full;
    assign count   = r_count;
    assign overrun = r_overrun;

`ifdef UART_RX_FIFO_IRQ_EN
    localparam logic [ADDR_W:0] C_IRQ_LEVEL = (ADDR_W+1)'(IRQ_LEVEL);

    logic r_irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= irq_en & ((w_count_next >= C_IRQ_LEVEL) | w_overrun_next);
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_irq_en;
    assign w_unused_irq_en = irq_en;
    assign irq             = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed self-checking bench for uart_rx_fifo (DEPTH=16,
//            IRQ_LEVEL=4); irq expectations follow UART_RX_FIFO_IRQ_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_dv;
    logic [7:0]        rx_byte;
    logic              rd;
    logic [7:0]        rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overrun;
    logic              clr_overrun;
    logic              irq_en;
    logic              irq;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_fifo #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .IRQ_LEVEL (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_dv       (rx_dv),
        .rx_byte     (rx_byte),
        .rd          (rd),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .irq_en      (irq_en),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " count"},   32'(count),   32'd0);
        check({tag, " empty"},   32'(empty),   32'd1);
        check({tag, " full"},    32'(full),    32'd0);
        check({tag, " overrun"}, 32'(overrun), 32'd0);
        check({tag, " irq"},     32'(irq),     32'd0);
        check({tag, " rd_data"}, 32'(rd_data), 32'h00);
    endtask

    task automatic push(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        step();
        rx_dv   = 1'b0;
    endtask

    task automatic pop();
        rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    logic irq_on;
    logic [7:0] exp_head;
    logic [7:0] exp_tail;

    initial begin
`ifdef UART_RX_FIFO_IRQ_EN
        irq_on = 1'b1;
`else
        irq_on = 1'b0;
`endif
        reset = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; rd = 1'b0;
        clr_overrun = 1'b0; irq_en = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_reset_state("reset");

        // Two pushes, then drain
        push(8'hA5);
        push(8'h3C);
        check("two push count", 32'(count), 32'd2);
        check("two push head",  32'(rd_data), 32'hA5);
        pop();
        check("pop1 head", 32'(rd_data), 32'h3C);
        pop();
        check("pop2 empty",   32'(empty), 32'd1);
        check("pop2 rd_data", 32'(rd_data), 32'h00);

        // 17 pushes into 16 entries: last byte dropped
        for (int i = 0; i < 17; i++) push(8'(i));
        check("fill full",    32'(full),    32'd1);
        check("fill count",   32'(count),   32'd16);
        check("fill overrun", 32'(overrun), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain %0d", i), 32'(rd_data), 32'(i));
            pop();
        end
        check("drain empty",   32'(empty), 32'd1);
        check("overrun sticky", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check("clr overrun", 32'(overrun), 32'd0);

        // Push+pop while full
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        rx_dv = 1'b1; rx_byte = 8'h77; rd = 1'b1;
        step();
        rx_dv = 1'b0; rd = 1'b0;
        check("full pp count",   32'(count),   32'd16);
        check("full pp overrun", 32'(overrun), 32'd0);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("full pp drain %0d", i), 32'(rd_data), 32'h20 + 32'(i));
            pop();
        end
        check("full pp last", 32'(rd_data), 32'h77);
        pop();
        check("full pp empty", 32'(empty), 32'd1);

        // Push+pop while empty
        rx_dv = 1'b1; rx_byte = 8'h42; rd = 1'b1;
        step();
        rx_dv = 1'b0; rd = 1'b0;
        check("empty pp count", 32'(count), 32'd1);
        check("empty pp head",  32'(rd_data), 32'h42);
        pop();
        check("pop to zero", 32'(count), 32'd0);
        pop();
        check("pop empty count", 32'(count), 32'd0);
        check("pop empty flag",  32'(empty), 32'd1);
        check("pop empty ovr",   32'(overrun), 32'd0);

        // 40 simultaneous push/pop pairs with one byte in flight: pointers wrap
        push(8'h80);
        exp_head = 8'h80;
        exp_tail = 8'h80;
        for (int i = 0; i < 40; i++) begin
            check($sformatf("wrap head %0d", i), 32'(rd_data), 32'(exp_head));
            exp_tail = exp_tail + 8'd1;
            rx_dv = 1'b1; rx_byte = exp_tail; rd = 1'b1;
            step();
            exp_head = exp_head + 8'd1;
            check($sformatf("wrap count %0d", i), 32'(count), 32'd1);
        end
        rx_dv = 1'b0; rd = 1'b0;
        check("wrap final head", 32'(rd_data), 32'h80 + 32'd40);
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        check("pre-reset count", 32'(count), 32'd5);
        reset = 1'b1; rx_dv = 1'b1; rx_byte = 8'hEE; rd = 1'b1;
        step();
        reset = 1'b0; rx_dv = 1'b0; rd = 1'b0;
        check_reset_state("mid reset");

        // Interrupt at level 4
        irq_en = 1'b1;
        for (int i = 0; i < 3; i++) push(8'h50 + 8'(i));
        check("irq below level", 32'(irq), 32'd0);
        push(8'h53);
        check("irq at level",  32'(irq), 32'(irq_on));
        check("irq count 4",   32'(count), 32'd4);
        pop();
        check("irq after pop", 32'(irq), 32'd0);
        irq_en = 1'b0;
        push(8'h54);
        check("irq masked count", 32'(count), 32'd4);
        check("irq masked",       32'(irq), 32'd0);
        irq_en = 1'b1;
        step();
        check("irq unmasked", 32'(irq), 32'(irq_on));
        check("irq head", 32'(rd_data), 32'h51);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte FIFO between the `uart_rx` receiver and the CPU's peripheral bus. It captures each byte that `uart_rx` signals with its one-cycle data-valid pulse, so bytes that arrive while the pipelined CPU is busy are not lost. The CPU pops bytes through the MEM-stage peripheral read. An optional level-sensitive interrupt request goes to the peripheral `irqout` path.

## Interface
- `DEPTH`, 16: number of byte entries; must be a power of two, ≥ 2.
- `ADDR_W`, 4: log2(`DEPTH`).
- `IRQ_LEVEL`, 1: fill level (1..`DEPTH`) at which the interrupt request asserts.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_dv`  in  1  one-cycle push strobe from `uart_rx` `o_Rx_DV`.
- `rx_byte`  in  8  received byte, valid when `rx_dv`=1.
- `rd`  in  1  pop request from the peripheral read decode (MEM stage).
- `rd_data`  out  8  head-of-queue byte; 8'h00 when empty.
- `empty`  out  1  count == 0.
- `full`  out  1  count == `DEPTH`.
- `count`  out  `ADDR_W`+1  current fill level, 0..`DEPTH`.
- `overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `clr_overrun`  in  1  clears `overrun` (peripheral status write).
- `irq_en`  in  1  interrupt mask from the peripheral control register.
- `irq`  out  1  registered, level-sensitive interrupt request.

## Operation
- Storage: `DEPTH` × 8 register array, plus write pointer `wp`, read pointer `rp` (each `ADDR_W` bits) and `count` (`ADDR_W`+1 bits).
  - The array is not reset; pointers and count are.
- Push: accepted when `rx_dv`=1 and (`full`=0 or an accepted pop occurs in the same cycle). Writes `mem[wp]`, then `wp` increments modulo `DEPTH`.
- Pop: accepted when `rd`=1 and `empty`=0. `rp` increments modulo `DEPTH`.
  - A pop while empty is ignored: no pointer or count change, no error flag.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Pointer wrap-around is by natural `ADDR_W`-bit overflow. Full and empty are both derived from `count`, never from pointer equality.
- Simultaneous events:
  - Push and pop while full: both accepted, `count` stays `DEPTH`, no overrun.
  - Push and pop while empty: push accepted, pop ignored, `count` becomes 1.
- Overrun: `rx_dv`=1 while full with no accepted pop. The byte is discarded, pointers are unchanged, and `overrun` is set.
  - `overrun` is cleared only by `clr_overrun` or `reset`.
  - If a set and a clear occur in the same cycle, set wins.
- `rd_data` is first-word-fall-through: `mem[rp]` when non-empty, otherwise 8'h00. This lets the MEM-stage load see the byte in the same cycle as its pop.

## Timing
- Reset values (cycle after `reset`=1 is sampled): `wp`=0, `rp`=0, `count`=0, `empty`=1, `full`=0, `overrun`=0, `irq`=0, `rd_data`=8'h00.
- Reset mid-operation discards all queued bytes; any push or pop in the reset cycle is ignored.
- Push latency: a byte strobed in cycle N appears on `rd_data` (if it is the head) and is counted in `count`/`empty` from cycle N+1.
- Pop: `rd_data` shows the current head combinationally. The next head appears in cycle N+1 after an accepted pop in cycle N.
- Throughput: one push and one pop per cycle.
- `empty`, `full` and `count` are registered-state derived, with no combinational path from `rx_dv` or `rd`.
- `irq` is registered: `irq` at N+1 = `irq_en` & ((`count`_next ≥ `IRQ_LEVEL`) | `overrun`_next).

## Configuration
- `UART_RX_FIFO_IRQ_EN`
  - Defined: the `irq` logic above is compiled in.
  - Undefined: `irq` is tied to 1'b0, `irq_en` is unused, and the `IRQ_LEVEL` comparator and `irq` register are removed. FIFO behaviour is identical otherwise.

## Test plan
- Reset, then push 8'hA5 and 8'h3C on two `rx_dv` strobes → `count`=2, `rd_data`=8'hA5; pop → `rd_data`=8'h3C next cycle; pop → `empty`=1, `rd_data`=8'h00.
- Push 17 bytes 8'h00..8'h10 into `DEPTH`=16 → `full`=1, `count`=16, `overrun`=1; pop 16 → sequence 8'h00..8'h0F; `clr_overrun` → `overrun`=0.
- Fill to 16, then assert `rx_dv` (8'h77) and `rd` in the same cycle → `count` stays 16, `overrun`=0, 8'h77 becomes the last byte popped.
- From empty, `rx_dv` (8'h42) and `rd` in the same cycle → `count`=1, `rd_data`=8'h42; a pop while empty leaves `count`=0.
- Run 40 push/pop pairs with pointer wrap → data order preserved and `count` never exceeds 16; assert `reset` with `count`=5 → all outputs at reset values next cycle.
- With `UART_RX_FIFO_IRQ_EN` defined, `IRQ_LEVEL`=4, `irq_en`=1: push 4 bytes → `irq` rises one cycle after the 4th push, falls one cycle after the pop to 3; with `irq_en`=0 → `irq` stays 0. With the macro undefined → `irq`=0 throughout.
